// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - ID/EX-side bundle of the iterative multiply/divide unit
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [5:0]      funct;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            flush;
  logic            busy;
  logic            stall_req;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, funct, rs_val, rt_val, flush,
    input  busy, stall_req, done, hi, lo
  );

  modport slave (
    input  start, funct, rs_val, rt_val, flush,
    output busy, stall_req, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ex_muldiv_unit_if.slave   bus
);
  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc;     // product high half / partial remainder
  logic [XLEN-1:0] mq;      // multiplier (shifts out) / quotient (shifts in)
  logic [XLEN-1:0] opb;     // multiplicand / divisor magnitude
  logic [XLEN-1:0] rs_raw;
  logic            is_div;
  logic            div0;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic            done_q;

  logic            op_muldiv;
  logic            op_signed;
  logic            op_div;
  logic            rs_neg;
  logic            rt_neg;
  logic [XLEN-1:0] rs_mag;
  logic [XLEN-1:0] rt_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic            div_ge;
  logic [XLEN-1:0] div_diff;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0] res_hi;
  logic [XLEN-1:0] res_lo;

  always_comb begin
    op_muldiv = (bus.funct == F_MULT) || (bus.funct == F_MULTU) ||
                (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
    op_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
    op_div    = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
    rs_neg    = op_signed & bus.rs_val[XLEN-1];
    rt_neg    = op_signed & bus.rt_val[XLEN-1];
    rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
    rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;
  end

  always_comb begin
    mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
    // The partial remainder is always below opb before the shift, so
    // the low XLEN bits of the subtraction are exact whenever it is taken.
    div_sh   = {acc, mq[XLEN-1]};
    div_ge   = div_sh >= {1'b0, opb};
    div_diff = div_sh[XLEN-1:0] - opb;
  end

  always_comb begin
    product = {acc, mq};
    if (neg_q) product = -product;
    res_hi = product[2*XLEN-1:XLEN];
    res_lo = product[XLEN-1:0];
    if (is_div) begin
      if (div0) begin
        res_lo = '1;
        res_hi = rs_raw;
      end else begin
        res_lo = neg_q ? -mq  : mq;
        res_hi = neg_r ? -acc : acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      opb    <= '0;
      rs_raw <= '0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              if (op_muldiv) begin
                state  <= S_CALC;
                cnt    <= '0;
                acc    <= '0;
                rs_raw <= bus.rs_val;
                is_div <= op_div;
                div0   <= op_div && (bus.rt_val == '0);
                neg_q  <= rs_neg ^ rt_neg;
                neg_r  <= op_div & rs_neg;
                mq     <= op_div ? rs_mag : rt_mag;
                opb    <= op_div ? rt_mag : rs_mag;
              end else if (bus.funct == F_MTHI) begin
                hi_q <= bus.rs_val;
              end else if (bus.funct == F_MTLO) begin
                lo_q <= bus.rs_val;
              end
            end
          end
          S_CALC: begin
            if (is_div) begin
              acc <= div_ge ? div_diff : div_sh[XLEN-1:0];
              mq  <= {mq[XLEN-2:0], div_ge};
            end else begin
              acc <= mul_sum[XLEN:1];
              mq  <= {mul_sum[0], mq[XLEN-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN - 1)) state <= S_FIN;
          end
          S_FIN: begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.stall_req = bus.start & (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - randomized and directed bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.XLEN(32)) bif ();
  ex_muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  function automatic void model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0] w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    eh = '0;
    el = '0;
    case (f)
      6'h18: begin sp = sa * sb; w = sp; eh = w[63:32]; el = w[31:0]; end
      6'h19: begin up = ua * ub; w = up; eh = w[63:32]; el = w[31:0]; end
      6'h1A: begin
        if (b == 0) begin el = '1; eh = a; end
        else begin sq = sa / sb; sr = sa % sb; w = sq; el = w[31:0]; w = sr; eh = w[31:0]; end
      end
      6'h1B: begin
        if (b == 0) begin el = '1; eh = a; end
        else begin el = a / b; eh = a % b; end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cyc);
    @(negedge clk);
    bif.start = 1'b1; bif.funct = f; bif.rs_val = a; bif.rt_val = b;
    lat = -1; busy_cyc = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bif.start = 1'b0;
      if (bif.busy) busy_cyc++;
      if (bif.done) begin lat = n; break; end
    end
  endtask

  task automatic check_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
    int lat, bc;
    logic [31:0] eh, el;
    model_op(f, a, b, eh, el);
    run_op(f, a, b, lat, bc);
    n_checks++;
    if (lat !== 34) begin n_fails++; $display("FAIL %s latency got %0d want 34", name, lat); end
    n_checks++;
    if (bc !== 33) begin n_fails++; $display("FAIL %s busy_cycles got %0d want 33", name, bc); end
    n_checks++;
    if (bif.hi !== eh || bif.lo !== el) begin
      n_fails++;
      $display("FAIL %s f=%h a=%h b=%h hi/lo got %h/%h want %h/%h", name, f, a, b, bif.hi, bif.lo, eh, el);
    end
    exp_hi = eh; exp_lo = el;
    @(negedge clk);
    n_checks++;
    if (bif.done !== 1'b0) begin n_fails++; $display("FAIL %s done_pulse got %b want 0", name, bif.done); end
  endtask

  task automatic test_reset();
    bif.start = 0; bif.funct = 0; bif.rs_val = 0; bif.rt_val = 0; bif.flush = 0;
    #2;
    n_checks++;
    if ({bif.busy, bif.done, bif.stall_req} !== 3'b000 || bif.hi !== 0 || bif.lo !== 0) begin
      n_fails++;
      $display("FAIL reset busy/done/stall=%b%b%b hi=%h lo=%h want all 0", bif.busy, bif.done, bif.stall_req, bif.hi, bif.lo);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [5:0]  f [8] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1A, 6'h1A, 6'h1A, 6'h19};
    logic [31:0] a [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h7, 32'h80000000, 32'hFFFFFFF9, 32'h7, 32'h0};
    logic [31:0] b [8] = '{32'h7, 32'hFFFFFFFF, 32'h2, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 32'h5};
    logic [31:0] eh[8] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h7, 32'h0, 32'hFFFFFFF9, 32'h1, 32'h0};
    logic [31:0] el[8] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0};
    int lat, bc;
    for (int i = 0; i < 8; i++) begin
      run_op(f[i], a[i], b[i], lat, bc);
      n_checks++;
      if (lat !== 34 || bc !== 33) begin
        n_fails++; $display("FAIL vec%0d timing lat=%0d busy=%0d want 34/33", i, lat, bc);
      end
      n_checks++;
      if (bif.hi !== eh[i] || bif.lo !== el[i]) begin
        n_fails++; $display("FAIL vec%0d hi/lo got %h/%h want %h/%h", i, bif.hi, bif.lo, eh[i], el[i]);
      end
      exp_hi = eh[i]; exp_lo = el[i];
    end
  endtask

  task automatic test_random();
    logic [5:0]  fs [4] = '{6'h18, 6'h19, 6'h1A, 6'h1B};
    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : $urandom;
      b = ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : $urandom;
      if ($urandom_range(1) == 1) b = b >> $urandom_range(31);
      check_op("random", fs[$urandom_range(3)], a, b);
    end
  endtask

  task automatic test_flush(input int at, input string name);
    int seen;
    @(negedge clk);
    bif.start = 1'b1; bif.funct = 6'h18; bif.rs_val = 32'h1234_5678; bif.rt_val = 32'h9;
    for (int n = 1; n <= at; n++) begin @(negedge clk); bif.start = 1'b0; end
    bif.flush = 1'b1;
    @(negedge clk);
    bif.flush = 1'b0;
    n_checks++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin
      n_fails++; $display("FAIL %s busy/done got %b/%b want 0/0", name, bif.busy, bif.done);
    end
    seen = 0;
    for (int n = 0; n < 40; n++) begin @(negedge clk); if (bif.done || bif.busy) seen++; end
    n_checks++;
    if (seen !== 0) begin n_fails++; $display("FAIL %s activity cycles got %0d want 0", name, seen); end
    n_checks++;
    if (bif.hi !== exp_hi || bif.lo !== exp_lo) begin
      n_fails++; $display("FAIL %s hi/lo got %h/%h want %h/%h", name, bif.hi, bif.lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_back_to_back_stall();
    int lat;
    logic [31:0] eh, el;
    model_op(6'h1A, 32'hFFFFFFF9, 32'h2, eh, el);
    @(negedge clk);
    bif.start = 1'b1; bif.funct = 6'h1A; bif.rs_val = 32'hFFFFFFF9; bif.rt_val = 32'h2;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bif.start = 1'b0;
      if (n == 5) begin
        bif.start = 1'b1; bif.funct = 6'h19; bif.rs_val = 32'h55; bif.rt_val = 32'h3;
        #1;
        n_checks++;
        if (bif.stall_req !== 1'b1) begin n_fails++; $display("FAIL stall_req got %b want 1", bif.stall_req); end
      end
      if (bif.done) begin lat = n; break; end
    end
    n_checks++;
    if (lat !== 34) begin n_fails++; $display("FAIL stall latency got %0d want 34", lat); end
    n_checks++;
    if (bif.hi !== eh || bif.lo !== el) begin
      n_fails++; $display("FAIL stall result hi/lo got %h/%h want %h/%h", bif.hi, bif.lo, eh, el);
    end
    exp_hi = eh; exp_lo = el;
  endtask

  task automatic test_mthi_mtlo();
    logic [5:0]  f  [4] = '{6'h13, 6'h11, 6'h11, 6'h20};
    logic [31:0] v  [4] = '{32'h1234, 32'hCAFE_0001, 32'hDEAD_BEEF, 32'h5555_AAAA};
    logic        fl [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bif.start = 1'b1; bif.funct = f[i]; bif.rs_val = v[i]; bif.rt_val = 32'h0; bif.flush = fl[i];
      @(negedge clk);
      bif.start = 1'b0; bif.flush = 1'b0;
      if (!fl[i] && f[i] == 6'h13) exp_lo = v[i];
      if (!fl[i] && f[i] == 6'h11) exp_hi = v[i];
      n_checks++;
      if (bif.hi !== exp_hi || bif.lo !== exp_lo || bif.busy !== 1'b0 || bif.done !== 1'b0) begin
        n_fails++;
        $display("FAIL mt%0d hi/lo/busy/done got %h/%h/%b/%b want %h/%h/0/0", i, bif.hi, bif.lo, bif.busy, bif.done, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    bif.start = 1'b1; bif.funct = 6'h18; bif.rs_val = 32'hFFFF_0003; bif.rt_val = 32'h77;
    for (int n = 1; n <= 20; n++) begin @(negedge clk); bif.start = 1'b0; end
    bif.start = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bif.busy, bif.done, bif.stall_req} !== 3'b000 || bif.hi !== 0 || bif.lo !== 0) begin
      n_fails++;
      $display("FAIL reset_midop busy/done/stall=%b%b%b hi=%h lo=%h want all 0", bif.busy, bif.done, bif.stall_req, bif.hi, bif.lo);
    end
    @(negedge clk);
    bif.start = 1'b0; rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0;
    check_op("post_reset_mult", 6'h18, 32'h2, 32'h3);
    n_checks++;
    if (bif.lo !== 32'h6 || bif.hi !== 32'h0) begin
      n_fails++; $display("FAIL post_reset_mult hi/lo got %h/%h want 0/6", bif.hi, bif.lo);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_flush(10, "flush_mid");
    test_flush(33, "flush_fin");
    test_back_to_back_stall();
    test_mthi_mtlo();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
